// File: rtl/mcfsm.sv
// mcfsm: multi-cycle main controller for the 32-bit RISC core.
// One shared ALU and one unified memory are sequenced through
// fetch/decode/execute/memory/writeback. The controller produces datapath
// enables, mux selects and the 2-bit aluop for aludec, and counts retired
// instructions. Decoded outputs depend on the current state and, where a
// memory handshake or branch condition is involved, on mem_ready or zero in
// the same cycle.
module mcfsm #(
    parameter int n   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           iord,
    output logic           irwrite,
    output logic           memwrite,
    output logic           regwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic           pcen,
    output logic [1:0]     aluop,
    output logic           illegal,
    output logic [n-1:0]   instret,
    output logic [3:0]     state
);

    // Opcode encodings
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(32'd0);
    localparam logic [OPW-1:0] OP_LW    = OPW'(32'd1);
    localparam logic [OPW-1:0] OP_SW    = OPW'(32'd2);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(32'd3);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(32'd4);
    localparam logic [OPW-1:0] OP_J     = OPW'(32'd5);

    // aludec control encodings; 2'b11 is never produced
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    // Next-PC selects
    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_JUMP     = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [n-1:0]   instret_q;
    logic [n-1:0]   instret_d;

    // Raw (pre-reset-gating) decoded controls
    logic           mem_req_s;
    logic           iord_s;
    logic           irwrite_s;
    logic           memwrite_s;
    logic           regwrite_s;
    logic           regdst_s;
    logic           memtoreg_s;
    logic           alusrca_s;
    logic [1:0]     alusrcb_s;
    logic [1:0]     pcsrc_s;
    logic           pcwrite_s;
    logic           branch_s;
    logic [1:0]     aluop_s;
    logic           illegal_s;
    logic           retire_s;

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic and raw decoded controls for the current state
    always_comb begin
        state_d    = state_q;
        mem_req_s  = 1'b0;
        iord_s     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = SRCB_RT;
        pcsrc_s    = PC_ALU;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        aluop_s    = ALUOP_ADD;
        illegal_s  = 1'b0;
        retire_s   = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed while the instruction is read
                mem_req_s = 1'b1;
                alusrcb_s = SRCB_FOUR;
                if (mem_ready) begin
                    irwrite_s = 1'b1;
                    pcwrite_s = 1'b1;
                    state_d   = S_DECODE;
                end else begin
                    state_d   = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode resolves
                alusrcb_s = SRCB_IMMSH;
                case (op)
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXEC;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JUMP;
                    default: begin
                        illegal_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    // Unreachable for a stable IR; recover to fetch
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (mem_ready) begin
                    memwrite_s = 1'b1;
                    retire_s   = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d    = S_MEMWR;
                end
            end
            S_EXEC: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_RT;
                aluop_s   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_RT;
                aluop_s   = ALUOP_SUB;
                pcsrc_s   = PC_ALUOUT;
                branch_s  = 1'b1;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_s   = PC_JUMP;
                pcwrite_s = 1'b1;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // Unused encodings fall back to fetch
                state_d = S_FETCH;
            end
        endcase

        if (retire_s) begin
            instret_d = instret_q + n'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // Output stage: force every control to its idle value while reset is high
    always_comb begin
        if (reset) begin
            mem_req  = 1'b0;
            iord     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            pcen     = 1'b0;
            aluop    = ALUOP_ADD;
            illegal  = 1'b0;
        end else begin
            mem_req  = mem_req_s;
            iord     = iord_s;
            irwrite  = irwrite_s;
            memwrite = memwrite_s;
            regwrite = regwrite_s;
            regdst   = regdst_s;
            memtoreg = memtoreg_s;
            alusrca  = alusrca_s;
            alusrcb  = alusrcb_s;
            pcsrc    = pcsrc_s;
            pcen     = pcwrite_s | (branch_s & zero);
            aluop    = aluop_s;
            illegal  = illegal_s;
        end
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mcfsm.sv
// tb_mcfsm: scoreboard bench for the multi-cycle controller. Each scenario
// pushes expected per-cycle output vectors alongside the stimulus for that
// cycle, then pops and compares them cycle by cycle. A narrow instret counter
// is used so the wrap-around can be reached quickly.
module tb_mcfsm;

    localparam int N   = 3;
    localparam int OPW = 4;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_ADDIEX = 4'd9;
    localparam logic [3:0] ST_ADDIWB = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_BAD   = 4'b1111;

    typedef struct packed {
        logic [3:0]   st;
        logic         mem_req;
        logic         iord;
        logic         irwrite;
        logic         memwrite;
        logic         regwrite;
        logic         regdst;
        logic         memtoreg;
        logic         alusrca;
        logic [1:0]   alusrcb;
        logic [1:0]   pcsrc;
        logic         pcen;
        logic [1:0]   aluop;
        logic         illegal;
        logic [N-1:0] instret;
    } vec_t;

    typedef struct packed {
        logic [3:0] op;
        logic       rdy;
        logic       z;
    } stim_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [OPW-1:0] op;
    logic           zero;
    logic           mem_ready;
    logic           mem_req, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]     alusrcb, pcsrc, aluop;
    logic           pcen, illegal;
    logic [N-1:0]   instret;
    logic [3:0]     state;

    vec_t           obs;
    vec_t           sb[$];
    stim_t          sq[$];
    logic [N-1:0]   exp_cnt;
    int             errors = 0;
    int             checks = 0;

    mcfsm #(.n(N), .OPW(OPW)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
        .aluop(aluop), .illegal(illegal), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, iord, irwrite, memwrite, regwrite, regdst,
                  memtoreg, alusrca, alusrcb, pcsrc, pcen, aluop, illegal, instret};

    // Expected controls for one cycle in state st, from the controller's state table
    function automatic vec_t exp_of(logic [3:0] st, logic [3:0] o, logic rdy, logic z,
                                    logic [N-1:0] cnt);
        vec_t e;
        e = '0;
        e.st = st;
        e.instret = cnt;
        case (st)
            ST_FETCH:  begin e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcen = rdy; end
            ST_DECODE: begin e.alusrcb = 2'b11; e.illegal = (o > 4'd5); end
            ST_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            ST_MEMRD:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
            ST_MEMWB:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            ST_MEMWR:  begin e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = rdy; end
            ST_EXEC:   begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            ST_ALUWB:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            ST_BRANCH: begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
            ST_ADDIEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            ST_ADDIWB: begin e.regwrite = 1'b1; end
            ST_JUMP:   begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default:   e = '0;
        endcase
        return e;
    endfunction

    task automatic push(logic [3:0] st, logic [3:0] o, logic rdy, logic z);
        stim_t s;
        s.op = o; s.rdy = rdy; s.z = z;
        sq.push_back(s);
        sb.push_back(exp_of(st, o, rdy, z, exp_cnt));
        if (st == ST_MEMWB || st == ST_ALUWB || st == ST_BRANCH || st == ST_ADDIWB ||
            st == ST_JUMP || (st == ST_MEMWR && rdy)) begin
            exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; op = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs !== vec_t'(0)) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, vec_t'(0));
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_rtype;
        vec_t e; stim_t s;
        push(ST_FETCH, OP_RTYPE, 1'b1, 1'b0);
        push(ST_DECODE, OP_RTYPE, 1'b1, 1'b0);
        push(ST_EXEC, OP_RTYPE, 1'b1, 1'b0);
        push(ST_ALUWB, OP_RTYPE, 1'b1, 1'b0);
        push(ST_FETCH, OP_RTYPE, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            s = sq.pop_front(); e = sb.pop_front();
            op = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rtype: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait;
        vec_t e; stim_t s;
        int irw = 0;
        int cyc = 0;
        int wb_cyc = 0;
        push(ST_FETCH, OP_LW, 1'b0, 1'b0);
        push(ST_FETCH, OP_LW, 1'b0, 1'b0);
        push(ST_FETCH, OP_LW, 1'b1, 1'b0);
        push(ST_DECODE, OP_LW, 1'b0, 1'b0);
        push(ST_MEMADR, OP_LW, 1'b1, 1'b0);
        push(ST_MEMRD, OP_LW, 1'b0, 1'b0);
        push(ST_MEMRD, OP_LW, 1'b0, 1'b0);
        push(ST_MEMRD, OP_LW, 1'b1, 1'b0);
        push(ST_MEMWB, OP_LW, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            s = sq.pop_front(); e = sb.pop_front();
            op = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            cyc++;
            if (irwrite === 1'b1) irw++;
            if (state === ST_MEMWB && wb_cyc == 0) wb_cyc = cyc;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lw_wait: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (irw != 1) begin
            errors++;
            $display("FAIL lw_irwrite_count: got %0d expected 1", irw);
        end
        checks++;
        if (wb_cyc != 9) begin
            errors++;
            $display("FAIL lw_latency: got %0d expected 9", wb_cyc);
        end
    endtask

    task automatic test_beq;
        vec_t e; stim_t s;
        push(ST_FETCH, OP_BEQ, 1'b1, 1'b1);
        push(ST_DECODE, OP_BEQ, 1'b1, 1'b1);
        push(ST_BRANCH, OP_BEQ, 1'b1, 1'b1);
        push(ST_FETCH, OP_BEQ, 1'b1, 1'b0);
        push(ST_DECODE, OP_BEQ, 1'b1, 1'b0);
        push(ST_BRANCH, OP_BEQ, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            s = sq.pop_front(); e = sb.pop_front();
            op = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL beq(zero=%0b): got %h expected %h", s.z, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal;
        vec_t e; stim_t s;
        push(ST_FETCH, OP_BAD, 1'b1, 1'b0);
        push(ST_DECODE, OP_BAD, 1'b1, 1'b0);
        push(ST_FETCH, OP_BAD, 1'b0, 1'b0);
        push(ST_FETCH, OP_BAD, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            s = sq.pop_front(); e = sb.pop_front();
            op = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        vec_t e; stim_t s;
        push(ST_FETCH, OP_SW, 1'b1, 1'b0);
        push(ST_DECODE, OP_SW, 1'b0, 1'b0);
        push(ST_MEMADR, OP_SW, 1'b0, 1'b0);
        push(ST_MEMWR, OP_SW, 1'b0, 1'b0);
        push(ST_MEMWR, OP_SW, 1'b1, 1'b0);
        push(ST_FETCH, OP_ADDI, 1'b1, 1'b0);
        push(ST_DECODE, OP_ADDI, 1'b1, 1'b0);
        push(ST_ADDIEX, OP_ADDI, 1'b1, 1'b0);
        push(ST_ADDIWB, OP_ADDI, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            s = sq.pop_front(); e = sb.pop_front();
            op = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_memwr;
        vec_t e; stim_t s;
        push(ST_FETCH, OP_SW, 1'b1, 1'b0);
        push(ST_DECODE, OP_SW, 1'b1, 1'b0);
        push(ST_MEMADR, OP_SW, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            s = sq.pop_front(); e = sb.pop_front();
            op = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_memwr_pre: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
        end
        // In MEMWR with mem_ready=1, but reset masks the write strobe
        reset = 1'b1; mem_ready = 1'b1;
        e = '0; e.st = ST_MEMWR; e.instret = exp_cnt;
        @(negedge clk);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_memwr_cycle: got %h expected %h", obs, e);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        exp_cnt = '0;
        e = exp_of(ST_FETCH, OP_SW, 1'b0, 1'b0, exp_cnt);
        @(negedge clk);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_memwr_after: got %h expected %h", obs, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        vec_t e; stim_t s;
        for (int k = 0; k < 8; k++) begin
            push(ST_FETCH, OP_J, 1'b1, 1'b0);
            push(ST_DECODE, OP_J, 1'b1, 1'b0);
            push(ST_JUMP, OP_J, 1'b1, 1'b0);
        end
        while (sb.size() != 0) begin
            s = sq.pop_front(); e = sb.pop_front();
            op = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (instret !== {N{1'b0}} || state !== ST_FETCH) begin
            errors++;
            $display("FAIL wrap_final: got instret=%0d state=%0d expected instret=0 state=0",
                     instret, state);
        end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_lw_wait;
        test_beq;
        test_illegal;
        test_back_to_back;
        test_reset_memwr;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
